// File: rtl/uart_tx_rr_sched.sv
// Round-robin scheduler that shares one UART transmitter among NREQ byte producers.
// One byte is outstanding at a time; a watchdog aborts a launch that the UART never acknowledges.
module uart_tx_rr_sched #(
  parameter int NREQ        = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [8*NREQ-1:0]         req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  input  logic                      tx_done,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      err,
  input  logic                      err_clr
);

  localparam int GW = $clog2(NREQ);
  localparam int WW = $clog2(ACK_TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] ID_LAST = GW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

  state_t          state_r, state_n;
  logic [GW-1:0]   rr_ptr_r, rr_ptr_n;
  logic [WW-1:0]   wdog_r, wdog_n;
  logic [GW-1:0]   grant_id_r;
  logic [7:0]      tx_data_r;
  logic            tx_start_r, busy_r, err_r;
  logic [GW-1:0]   sel_s, next_ptr_s;
  logic            found_s, grant_s, err_set_s;
  logic [NREQ-1:0] req_ready_s;

  // Circular priority search starting at rr_ptr, plus the one-hot ready it drives.
  always_comb begin
    sel_s       = '0;
    found_s     = 1'b0;
    req_ready_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && req_valid[(int'(rr_ptr_r) + k) % NREQ]) begin
        found_s = 1'b1;
        sel_s   = GW'((int'(rr_ptr_r) + k) % NREQ);
      end else begin
        found_s = found_s;
      end
    end
    grant_s = (state_r == IDLE) && tx_done && found_s;
    if (grant_s) begin
      req_ready_s[sel_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
    next_ptr_s = (grant_id_r == ID_LAST) ? '0 : grant_id_r + GW'(1);
  end

  // Next-state, watchdog and pointer update.
  always_comb begin
    state_n   = state_r;
    rr_ptr_n  = rr_ptr_r;
    wdog_n    = wdog_r;
    err_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_s) state_n = LAUNCH;
        else         state_n = IDLE;
      end
      LAUNCH: begin
        state_n = WAIT_ACK;
        wdog_n  = '0;
      end
      WAIT_ACK: begin
        if (!tx_done) begin
          state_n = WAIT_DONE;
        end else if (wdog_r == WD_LAST) begin
          // The UART never left idle: drop the byte and move on.
          err_set_s = 1'b1;
          rr_ptr_n  = next_ptr_s;
          state_n   = IDLE;
        end else begin
          wdog_n = wdog_r + WW'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_n  = IDLE;
          rr_ptr_n = next_ptr_s;
        end else begin
          state_n = WAIT_DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      wdog_r     <= '0;
      grant_id_r <= '0;
      tx_data_r  <= 8'h00;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_n;
      rr_ptr_r   <= rr_ptr_n;
      wdog_r     <= wdog_n;
      tx_start_r <= (state_n == LAUNCH);
      busy_r     <= (state_n != IDLE);
      if (grant_s) begin
        tx_data_r  <= req_data[{sel_s, 3'b000} +: 8];
        grant_id_r <= sel_s;
      end
      if (err_set_s)    err_r <= 1'b1;
      else if (err_clr) err_r <= 1'b0;
    end
  end

  assign req_ready = req_ready_s;
  assign tx_start  = tx_start_r;
  assign tx_data   = tx_data_r;
  assign grant_id  = grant_id_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: tb/tb_uart_tx_rr_sched.sv
// Bench for uart_tx_rr_sched: directed vector table, hand-written corner sequences,
// and random traffic checked against a transaction-level reference model.
module tb_uart_tx_rr_sched;
  localparam int N  = 4;
  localparam int TO = 16;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [3:0]  req_valid = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b1;
  logic [1:0]  grant_id;
  logic        busy, err;
  logic        err_clr = 1'b0;

  uart_tx_rr_sched #(.NREQ(N), .ACK_TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_err = 0;
  int cyc_no = 0;

  // reference model: one outstanding byte, aged in cycles since its transfer edge
  bit         m_busy, m_acked, m_err;
  int         m_age, m_ptr, m_gid;
  logic [7:0] m_data;

  // uart responder
  bit u_armed;
  int u_wait, u_cnt;

  int q_id[$];
  int q_data[$];
  int q_t[$];

  typedef struct {
    logic [3:0] v; logic [31:0] d; logic done; logic clr;
    logic [3:0] ready; logic start; logic [7:0] data; logic busy; logic [1:0] gid; logic err;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  function automatic int m_pick(input logic [3:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_busy = 0; m_acked = 0; m_err = 0; m_age = 0; m_ptr = 0; m_gid = 0; m_data = 8'h00;
    u_armed = 0; u_wait = 0; u_cnt = 0;
  endtask

  // drive one cycle's inputs, compare with the model, then advance the model past the edge
  task automatic cyc(input logic [3:0] v, input logic [31:0] d, input logic done, input logic clr);
    logic [3:0] e_ready;
    int p;
    bit set;
    @(negedge PCLK);
    req_valid = v; req_data = d; tx_done = done; err_clr = clr;
    cyc_no++;
    #1;
    p = m_pick(v);
    e_ready = (!m_busy && done && p >= 0) ? 4'(1 << p) : 4'b0000;
    chk("mdl_ready", req_ready, e_ready);
    chk("mdl_start", tx_start, (m_busy && m_age == 1));
    chk("mdl_busy", busy, m_busy);
    chk("mdl_data", tx_data, m_data);
    chk("mdl_gid", grant_id, m_gid);
    chk("mdl_err", err, m_err);
    set = 0;
    if (!m_busy) begin
      if (e_ready != 4'b0000) begin
        m_busy = 1; m_age = 1; m_acked = 0; m_gid = p; m_data = d[8*p +: 8];
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (!m_acked) begin
      if (!done) m_acked = 1;
      else if (m_age - 2 == TO - 1) begin
        set = 1; m_busy = 0; m_ptr = (m_gid + 1) % N;
      end else m_age++;
    end else if (done) begin
      m_busy = 0; m_ptr = (m_gid + 1) % N;
    end
    if (set) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  function automatic logic u_done();
    return (u_armed && u_wait == 0 && u_cnt > 0) ? 1'b0 : 1'b1;
  endfunction

  task automatic u_step(input bit ack, input int w, input int len);
    if (u_armed) begin
      if (u_wait > 0) u_wait--;
      else if (u_cnt > 0) u_cnt--;
      if (u_cnt == 0) u_armed = 0;
    end
    if (tx_start && ack) begin
      u_armed = 1; u_wait = w; u_cnt = len;
    end
  endtask

  task automatic run(input logic [3:0] v, input logic [31:0] d, input bit ack, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(v, d, u_done(), 1'b0);
      if (tx_start) begin
        q_id.push_back(int'(grant_id)); q_data.push_back(int'(tx_data)); q_t.push_back(cyc_no);
      end
      u_step(ack, 0, 3);
    end
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESET = 1'b1; req_valid = 4'b0000; tx_done = 1'b1; err_clr = 1'b0;
    m_reset();
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    q_id.delete(); q_data.delete(); q_t.delete();
  endtask

  initial begin
    tbl[0]  = '{4'b0001, 32'hAABBCC55, 1'b1, 1'b0, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 4'b0000, 1'b1, 8'h55, 1'b1, 2'd0, 1'b0};
    tbl[2]  = '{4'b0000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h55, 1'b1, 2'd0, 1'b0};
    tbl[3]  = '{4'b0000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h55, 1'b1, 2'd0, 1'b0};
    tbl[4]  = '{4'b0000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h55, 1'b1, 2'd0, 1'b0};
    tbl[5]  = '{4'b0010, 32'h00000000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h55, 1'b1, 2'd0, 1'b0};
    tbl[6]  = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h55, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{4'b0100, 32'h00000000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h55, 1'b0, 2'd0, 1'b0};
    tbl[8]  = '{4'b0000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h55, 1'b0, 2'd0, 1'b0};
    tbl[9]  = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h55, 1'b0, 2'd0, 1'b0};
    tbl[10] = '{4'b0001, 32'h44332211, 1'b1, 1'b0, 4'b0001, 1'b0, 8'h55, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 4'b0000, 1'b1, 8'h11, 1'b1, 2'd0, 1'b0};
    tbl[12] = '{4'b0000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h11, 1'b1, 2'd0, 1'b0};
    tbl[13] = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h11, 1'b1, 2'd0, 1'b0};
    tbl[14] = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h11, 1'b0, 2'd0, 1'b0};

    // reset values, then single-requester launch and a valid dropped while the uart is busy
    do_reset();
    #1;
    chk("rst_outputs", {req_ready, tx_start, tx_data, grant_id, busy, err}, 32'h0);
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].done, tbl[i].clr);
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].ready);
      chk($sformatf("tbl%0d_start", i), tx_start, tbl[i].start);
      chk($sformatf("tbl%0d_data", i), tx_data, tbl[i].data);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_gid", i), grant_id, tbl[i].gid);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
    end

    // all four valid: grant order 0,1,2,3,0 and frame+3 spacing
    do_reset();
    run(4'b1111, 32'hA3A2A1A0, 1'b1, 34);
    chk("t2_count", q_id.size() >= 5, 1);
    for (int i = 0; i < 5; i++) begin
      if (i < q_id.size()) begin
        chk($sformatf("t2_id%0d", i), q_id[i], i % 4);
        chk($sformatf("t2_data%0d", i), q_data[i], 32'hA0 + (i % 4));
      end
    end
    if (q_t.size() >= 2) chk("t2_spacing", q_t[1] - q_t[0], 6);

    // req1 and req3 with rr_ptr at 2: req3 first
    do_reset();
    run(4'b0010, 32'h0, 1'b1, 6);
    chk("t3_prime", (q_id.size() == 1) ? q_id[0] : -1, 1);
    q_id.delete();
    run(4'b1010, 32'h0, 1'b1, 12);
    chk("t3_first", (q_id.size() >= 1) ? q_id[0] : -1, 3);
    chk("t3_second", (q_id.size() >= 2) ? q_id[1] : -1, 1);

    // watchdog: no acknowledge, set wins over clear, then clear and next requester
    do_reset();
    cyc(4'b0001, 32'h0000005A, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cyc(4'b0000, 32'h0, 1'b1, 1'b0);
    cyc(4'b0000, 32'h0, 1'b1, 1'b1);
    chk("t4_err_before", err, 1'b0);
    chk("t4_busy_before", busy, 1'b1);
    cyc(4'b0000, 32'h0, 1'b1, 1'b0);
    chk("t4_err_set", err, 1'b1);
    chk("t4_idle", busy, 1'b0);
    cyc(4'b0000, 32'h0, 1'b1, 1'b1);
    cyc(4'b1111, 32'h0, 1'b1, 1'b0);
    chk("t4_err_clr", err, 1'b0);
    chk("t4_next_req", req_ready, 4'b0010);

    // asynchronous reset in WAIT_DONE
    do_reset();
    run(4'b1111, 32'hA3A2A1A0, 1'b1, 10);
    chk("t5_busy_pre", busy, 1'b1);
    @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    chk("t5_async", {tx_start, tx_data, grant_id, busy, err, req_ready}, 32'h0);
    m_reset();
    @(negedge PCLK);
    PRESET = 1'b0;
    cyc(4'b1111, 32'hA3A2A1A0, 1'b1, 1'b0);
    chk("t5_first", req_ready, 4'b0001);

    // random traffic with a misbehaving uart
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic d;
      bit ack;
      d = u_done();
      if (!u_armed && $urandom_range(0, 15) == 0) d = 1'b0;
      cyc(4'($urandom), $urandom, d, ($urandom_range(0, 7) == 0));
      ack = ($urandom_range(0, 9) != 0);
      u_step(ack, $urandom_range(0, 3), $urandom_range(1, 5));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
